// File: rtl/interp_tile_stepper.sv
// Raster tile walker: one (x, y, value) pixel per handshake, values by incremental add; INTERP_TILE_SAT_EN saturates pix_val.
// First pixel 1 cycle after coef accept; outputs hold while pix_ready is low, abort/reset drop the stream.
module interp_tile_stepper #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32,
  parameter int ACC_W  = 48
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic [31:0] ddx,
  input  logic [31:0] ddy,
  input  logic [31:0] c0,
  input  logic [10:0] tile_x,
  input  logic [10:0] tile_y,
  input  logic        abort,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [31:0] pix_val,
  output logic        pix_last,
  output logic        tile_done
);

  localparam int IW = $clog2(TILE_W);
  localparam int JW = $clog2(TILE_H);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] ddx_q, ddx_d, ddy_q, ddy_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_row_q, acc_row_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic [10:0]             tx_q, tx_d, ty_q, ty_d;
  logic                    done_q, done_d;
  logic                    row_end, last_row;

  assign row_end  = (i_q == IW'(TILE_W - 1));
  assign last_row = (j_q == JW'(TILE_H - 1));

  always_comb begin
    state_d   = state_q;
    ddx_d     = ddx_q;
    ddy_d     = ddy_q;
    acc_d     = acc_q;
    acc_row_d = acc_row_q;
    i_d       = i_q;
    j_d       = j_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (coef_valid) begin
          ddx_d     = {{(ACC_W-32){ddx[31]}}, ddx};
          ddy_d     = {{(ACC_W-32){ddy[31]}}, ddy};
          acc_d     = {{(ACC_W-32){c0[31]}}, c0};
          acc_row_d = {{(ACC_W-32){c0[31]}}, c0};
          i_d       = '0;
          j_d       = '0;
          tx_d      = tile_x;
          ty_d      = tile_y;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident handshake and suppresses tile_done.
        if (abort) begin
          state_d = IDLE;
        end else if (pix_ready) begin
          if (!row_end) begin
            i_d   = i_q + IW'(1);
            acc_d = acc_q + ddx_q;
          end else if (!last_row) begin
            i_d       = '0;
            j_d       = j_q + JW'(1);
            acc_row_d = acc_row_q + ddy_q;
            acc_d     = acc_row_q + ddy_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ddx_q     <= '0;
      ddy_q     <= '0;
      acc_q     <= '0;
      acc_row_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ddx_q     <= ddx_d;
      ddy_q     <= ddy_d;
      acc_q     <= acc_d;
      acc_row_q <= acc_row_d;
      i_q       <= i_d;
      j_q       <= j_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      done_q    <= done_d;
    end
  end

  assign coef_ready = (state_q == IDLE);
  assign pix_valid  = (state_q == RUN);
  assign pix_x      = tx_q + 11'(i_q);
  assign pix_y      = ty_q + 11'(j_q);
  assign pix_last   = (state_q == RUN) && row_end && last_row;
  assign tile_done  = done_q;

`ifdef INTERP_TILE_SAT_EN
  logic [ACC_W-32:0] acc_hi;
  assign acc_hi = acc_q[ACC_W-1:31];
  // In range only when the bits above 30 are a pure sign extension.
  always_comb begin
    if (&acc_hi || ~|acc_hi) pix_val = acc_q[31:0];
    else if (acc_q[ACC_W-1]) pix_val = 32'h8000_0000;
    else                     pix_val = 32'h7FFF_FFFF;
  end
`else
  assign pix_val = acc_q[31:0];
`endif

endmodule

// File: tb/tb_interp_tile_stepper.sv
// Directed bench for interp_tile_stepper: ramp, stall, negative steps, overflow, abort, reset, coef-during-run.
module tb_interp_tile_stepper;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        coef_valid;
  logic        coef_ready;
  logic [31:0] ddx, ddy, c0;
  logic [10:0] tile_x, tile_y;
  logic        abort;
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] pix_x, pix_y;
  logic [31:0] pix_val;
  logic        pix_last;
  logic        tile_done;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  interp_tile_stepper #(.TILE_W(32), .TILE_H(32), .ACC_W(48)) dut (
    .clock(clock), .reset_n(reset_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .ddx(ddx), .ddy(ddy), .c0(c0), .tile_x(tile_x), .tile_y(tile_y),
    .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val),
    .pix_last(pix_last), .tile_done(tile_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (pix_valid && pix_ready) hs_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_val(input logic [31:0] c, input logic [31:0] dx,
                                            input logic [31:0] dy, input int i, input int j);
    longint v;
    v = longint'($signed(c)) + longint'(i) * longint'($signed(dx)) + longint'(j) * longint'($signed(dy));
`ifdef INTERP_TILE_SAT_EN
    if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  localparam logic [31:0] N_C0 = 32'h1234_5678;
  localparam logic [10:0] N_TX = 11'd5;
  localparam logic [10:0] N_TY = 11'd7;

  task automatic run_tile(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] c,
                          input logic [10:0] tx, input logic [10:0] ty,
                          input int stall_at, input int abort_at, input int rst_at, input bit noise,
                          input int probe_k, input logic [10:0] px, input logic [10:0] py,
                          input logic [31:0] pv);
    int hs0;
    logic [10:0] ex, ey;
    logic [31:0] hx, hy, hv;
    coef_valid = 1'b1; ddx = dx; ddy = dy; c0 = c; tile_x = tx; tile_y = ty;
    @(negedge clock);
    hs0 = hs_cnt;
    if (noise) begin
      ddx = 32'h0BAD_0000; ddy = 32'h0DEA_D000; c0 = N_C0; tile_x = N_TX; tile_y = N_TY;
    end else begin
      coef_valid = 1'b0;
    end
    for (int k = 0; k < 1024; k++) begin
      ex = tx + 11'(k % 32);
      ey = ty + 11'(k / 32);
      chk("pix_valid", {63'd0, pix_valid}, 64'd1);
      chk("coef_ready_run", {63'd0, coef_ready}, 64'd0);
      chk("pix_x", {53'd0, pix_x}, {53'd0, ex});
      chk("pix_y", {53'd0, pix_y}, {53'd0, ey});
      chk("pix_val", {32'd0, pix_val}, {32'd0, model_val(c, dx, dy, k % 32, k / 32)});
      chk("pix_last", {63'd0, pix_last}, {63'd0, (k == 1023)});
      if (k == probe_k) begin
        chk("probe_x", {53'd0, pix_x}, {53'd0, px});
        chk("probe_y", {53'd0, pix_y}, {53'd0, py});
        chk("probe_val", {32'd0, pix_val}, {32'd0, pv});
      end
      if (k == stall_at) begin
        hx = {21'd0, pix_x}; hy = {21'd0, pix_y}; hv = pix_val;
        pix_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          chk("stall_valid", {63'd0, pix_valid}, 64'd1);
          chk("stall_x", {53'd0, pix_x}, {32'd0, hx});
          chk("stall_y", {53'd0, pix_y}, {32'd0, hy});
          chk("stall_val", {32'd0, pix_val}, {32'd0, hv});
        end
        pix_ready = 1'b1;
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_valid", {63'd0, pix_valid}, 64'd0);
        chk("abort_done", {63'd0, tile_done}, 64'd0);
        chk("abort_coef_ready", {63'd0, coef_ready}, 64'd1);
        return;
      end
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, pix_valid}, 64'd0);
        chk("rst_coef_ready", {63'd0, coef_ready}, 64'd1);
        chk("rst_last", {63'd0, pix_last}, 64'd0);
        chk("rst_done", {63'd0, tile_done}, 64'd0);
        chk("rst_xy", {42'd0, pix_x, pix_y}, 64'd0);
        chk("rst_val", {32'd0, pix_val}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        return;
      end
      @(negedge clock);
    end
    chk("tile_done", {63'd0, tile_done}, 64'd1);
    chk("done_valid", {63'd0, pix_valid}, 64'd0);
    chk("done_coef_ready", {63'd0, coef_ready}, 64'd1);
    chk("hs_count", 64'(hs_cnt - hs0), 64'd1024);
    @(negedge clock);
    chk("done_pulse", {63'd0, tile_done}, 64'd0);
    if (noise) begin
      chk("next_valid", {63'd0, pix_valid}, 64'd1);
      chk("next_x", {53'd0, pix_x}, {53'd0, N_TX});
      chk("next_y", {53'd0, pix_y}, {53'd0, N_TY});
      chk("next_val", {32'd0, pix_val}, {32'd0, N_C0});
      coef_valid = 1'b0;
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("next_abort", {63'd0, pix_valid}, 64'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; coef_valid = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    ddx = '0; ddy = '0; c0 = '0; tile_x = '0; tile_y = '0;
    repeat (2) @(negedge clock);
    chk("reset_coef_ready", {63'd0, coef_ready}, 64'd1);
    chk("reset_valid", {63'd0, pix_valid}, 64'd0);
    chk("reset_last", {63'd0, pix_last}, 64'd0);
    chk("reset_done", {63'd0, tile_done}, 64'd0);
    chk("reset_xy", {42'd0, pix_x, pix_y}, 64'd0);
    chk("reset_val", {32'd0, pix_val}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    // also exercises abort-in-IDLE having no effect
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("idle_abort", {63'd0, coef_ready}, 64'd1);

    run_tile(32'h0001_0000, 32'h0002_0000, 32'h0, 11'd64, 11'd32, 40, -1, -1, 1'b0,
             67, 11'd67, 11'd34, 32'h0007_0000);
    run_tile(32'hFFFF_0000, 32'h0, 32'h0010_0000, 11'd2047, 11'd2040, -1, -1, -1, 1'b0,
             31, 11'd30, 11'd2040, 32'hFFF1_0000);
`ifdef INTERP_TILE_SAT_EN
    run_tile(32'h0001_0000, 32'h0, 32'h7FFF_0000, 11'd0, 11'd0, -1, 2, -1, 1'b0,
             1, 11'd1, 11'd0, 32'h7FFF_FFFF);
`else
    run_tile(32'h0001_0000, 32'h0, 32'h7FFF_0000, 11'd0, 11'd0, -1, 2, -1, 1'b0,
             1, 11'd1, 11'd0, 32'h8000_0000);
`endif
    run_tile(32'h0001_0000, 32'h0002_0000, 32'h0, 11'd64, 11'd32, -1, 100, -1, 1'b0,
             100, 11'd68, 11'd35, 32'h000A_0000);
    run_tile(32'h0001_0000, 32'h0002_0000, 32'h0, 11'd64, 11'd32, -1, -1, 50, 1'b0,
             50, 11'd82, 11'd33, 32'h0014_0000);
    run_tile(32'h0001_0000, 32'h0002_0000, 32'h0, 11'd64, 11'd32, -1, -1, -1, 1'b1,
             0, 11'd64, 11'd32, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
